// File: rtl/restoring_div64by32.sv
// Sequential restoring divider, 64/32 -> 32-bit quotient and remainder, one quotient bit per clock.
// Optional macro DIV_ERR_FAST_EN: overflow/divide-by-zero results complete on the edge after accept.
module restoring_div64by32 (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        do_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        ovf_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t      state_q, state_d;
    logic [63:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] pr_q, pr_d;
    logic [31:0] q_q, q_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [32:0] shift_w;
    logic [32:0] diff_w;

    // Partial remainder stays below the divisor on valid operands, so 32 bits of pr suffice;
    // the bit shifted out lands in shift_w[32] and drives the trial subtraction.
    assign shift_w = {pr_q, dvd_q[cnt_q]};
    assign diff_w  = shift_w - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (do_i) begin
                    dvd_d   = dividend_i;
                    dvs_d   = divisor_i;
                    pr_d    = dividend_i[63:32];
                    q_d     = '0;
                    cnt_d   = 5'd31;
                    err_d   = (divisor_i == 32'd0) || (dividend_i[63:32] >= divisor_i);
                    busy_d  = 1'b1;
                    state_d = CALC;
`ifdef DIV_ERR_FAST_EN
                    if (err_d) state_d = FIN;
`endif
                end
            end
            CALC: begin
                if (!diff_w[32]) begin
                    pr_d = diff_w[31:0];
                    q_d  = {q_q[30:0], 1'b1};
                end else begin
                    pr_d = shift_w[31:0];
                    q_d  = {q_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd0) state_d = FIN;
                else               cnt_d   = cnt_q - 5'd1;
            end
            FIN: begin
                if (err_q) begin
                    quot_d = 32'hFFFF_FFFF;
                    rem_d  = dvd_q[31:0];
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = q_q;
                    rem_d  = pr_q;
                    ovf_d  = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
